result_collector: RTL and testbench

RESULT_COLLECTOR -- requirements
Module: result_collector

---
 rtl/result_collector_pkg.sv | 15 +
 rtl/result_collector_if.sv | 29 ++
 rtl/result_collector_nonce_fifo.sv | 68 ++++++
 rtl/result_collector.sv | 116 +++++++++++
 tb/tb_result_collector.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/result_collector_pkg.sv
// Shared definitions for the result collector: FSM state codes and default
// parameter values used by the collector, its nonce FIFO and the bus interface.
package result_collector_pkg;

  localparam int DEF_DEPTH   = 4;
  localparam int DEF_NONCE_W = 32;
  localparam int DEF_HIT_W   = 8;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE      = 2'd0;
  localparam logic [STATE_W-1:0] ST_MINING    = 2'd1;
  localparam logic [STATE_W-1:0] ST_EXHAUSTED = 2'd2;

endpackage

// File: rtl/result_collector_if.sv
// Result/nonce bus between the hashing core, the collector and the nonce consumer.
// master = producer/consumer side, slave = the collector.
interface result_collector_if #(
  parameter int NONCE_W = result_collector_pkg::DEF_NONCE_W,
  parameter int HIT_W   = result_collector_pkg::DEF_HIT_W
);

  logic               resultValid;
  logic               success;
  logic               newBlockIn;
  logic [NONCE_W-1:0] nonceOut;
  logic               nonceValid;
  logic               nonceReady;
  logic               overflow;
  logic               exhausted;
  logic [HIT_W-1:0]   hitCount;
  logic               blockActive;

  modport master (
    output resultValid, success, newBlockIn, nonceReady,
    input  nonceOut, nonceValid, overflow, exhausted, hitCount, blockActive
  );

  modport slave (
    input  resultValid, success, newBlockIn, nonceReady,
    output nonceOut, nonceValid, overflow, exhausted, hitCount, blockActive
  );

endinterface

// File: rtl/result_collector_nonce_fifo.sv
// Show-ahead FIFO of winning nonce indices. A push refused because the FIFO is
// full (and not popping this cycle) is silently dropped; the caller flags it.
module nonce_fifo #(
  parameter int DEPTH   = result_collector_pkg::DEF_DEPTH,
  parameter int NONCE_W = result_collector_pkg::DEF_NONCE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [NONCE_W-1:0] din,
  input  logic               pop,
  output logic [NONCE_W-1:0] dout,
  output logic               valid,
  output logic               full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [NONCE_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic               empty;
  logic               do_push;
  logic               do_pop;

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);
  assign valid = !empty;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Forcing zero while empty keeps the output defined without clearing storage.
  assign dout = empty ? '0 : mem[rd_ptr];

  // NOTE: storage has no reset; occupancy is tracked by count/pointers, so stale
  // words are never observed and the array can map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/result_collector.sv
// Collects hash results for the current block: numbers each result, queues the
// indices of winning results, and keeps per-block hit/overflow/exhaustion status.
module result_collector
  import result_collector_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int NONCE_W = DEF_NONCE_W,
  parameter int HIT_W   = DEF_HIT_W
) (
  input  logic               clk,
  input  logic               rst,
  result_collector_if.slave  bus
);

  localparam logic [HIT_W-1:0] HIT_MAX = {HIT_W{1'b1}};

  logic [STATE_W-1:0] state;
  logic [NONCE_W-1:0] counter;
  logic               overflow;
  logic               exhausted;
  logic [HIT_W-1:0]   hit_count;

  logic               accept;
  logic               wrap;
  logic [NONCE_W-1:0] index;
  logic               push;
  logic               pop;
  logic               drop;
  logic [HIT_W-1:0]   hit_base;
  logic [HIT_W-1:0]   hit_next;

  logic [NONCE_W-1:0] fifo_dout;
  logic               fifo_valid;
  logic               fifo_full;

  // NOTE: every always_comb output gets a value on every path (defaults first),
  // so no latches can be inferred when branches are added later.
  always_comb begin
    accept   = 1'b0;
    wrap     = 1'b0;
    index    = counter;
    push     = 1'b0;
    pop      = 1'b0;
    drop     = 1'b0;
    hit_base = hit_count;
    hit_next = hit_count;

    // Outside MINING only a block-opening result is looked at.
    accept = bus.resultValid && (bus.newBlockIn || (state == ST_MINING));
    if (bus.newBlockIn) begin
      index    = '0;
      hit_base = '0;
    end
    wrap = accept && !bus.newBlockIn && (counter == '1);
    push = accept && bus.success;
    pop  = fifo_valid && bus.nonceReady;
    drop = push && fifo_full && !pop;

    if (bus.success && (hit_base != HIT_MAX)) begin
      hit_next = hit_base + HIT_W'(1);
    end else begin
      hit_next = hit_base;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      counter   <= '0;
      overflow  <= 1'b0;
      exhausted <= 1'b0;
      hit_count <= '0;
    end else if (accept) begin
      hit_count <= hit_next;
      if (bus.newBlockIn) begin
        // Result 0 of the new block is processed on the same edge as the clear,
        // so a drop of result 0 itself still counts against the new block.
        state     <= ST_MINING;
        counter   <= NONCE_W'(1);
        overflow  <= drop;
        exhausted <= 1'b0;
      end else begin
        counter  <= counter + NONCE_W'(1);
        overflow <= overflow | drop;
        if (wrap) begin
          state     <= ST_EXHAUSTED;
          exhausted <= 1'b1;
        end
      end
    end
  end

  nonce_fifo #(
    .DEPTH   (DEPTH),
    .NONCE_W (NONCE_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (index),
    .pop   (pop),
    .dout  (fifo_dout),
    .valid (fifo_valid),
    .full  (fifo_full)
  );

  assign bus.nonceOut    = fifo_dout;
  assign bus.nonceValid  = fifo_valid;
  assign bus.overflow    = overflow;
  assign bus.exhausted   = exhausted;
  assign bus.hitCount    = hit_count;
  assign bus.blockActive = (state == ST_MINING) || (state == ST_EXHAUSTED);

endmodule

// File: tb/tb_result_collector.sv
// Bench for result_collector: directed block scenarios followed by random traffic,
// all outputs compared every cycle against a queue-based behavioural model.
module tb_result_collector;

  localparam int DEPTH   = 4;
  localparam int NONCE_W = 4;
  localparam int HIT_W   = 3;
  localparam int IDX_MOD = 1 << NONCE_W;
  localparam int HIT_SAT = (1 << HIT_W) - 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  result_collector_if #(.NONCE_W(NONCE_W), .HIT_W(HIT_W)) bus ();

  result_collector #(
    .DEPTH   (DEPTH),
    .NONCE_W (NONCE_W),
    .HIT_W   (HIT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: block bookkeeping in plain integers, FIFO as a queue.
  int q[$];
  bit in_block;
  bit counting;
  bit m_ovf;
  bit m_exh;
  int next_index;
  int m_hits;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    q.delete();
    in_block   = 1'b0;
    counting   = 1'b0;
    m_ovf      = 1'b0;
    m_exh      = 1'b0;
    next_index = 0;
    m_hits     = 0;
  endtask

  task automatic model_edge(input bit rv, input bit succ, input bit nb, input bit rdy);
    int idx;
    if (rdy && q.size() > 0) void'(q.pop_front());
    if (rv && (nb || counting)) begin
      idx = nb ? 0 : next_index;
      if (nb) begin
        m_ovf    = 1'b0;
        m_exh    = 1'b0;
        m_hits   = 0;
        in_block = 1'b1;
        counting = 1'b1;
      end
      if (succ) begin
        if (m_hits < HIT_SAT) m_hits++;
        if (q.size() < DEPTH) q.push_back(idx);
        else m_ovf = 1'b1;
      end
      if (idx == IDX_MOD - 1) begin
        m_exh    = 1'b1;
        counting = 1'b0;
      end
      next_index = (idx + 1) % IDX_MOD;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".nonceValid"},  32'(bus.nonceValid),  32'(q.size() > 0));
    check({tag, ".nonceOut"},    32'(bus.nonceOut),    (q.size() > 0) ? 32'(q[0]) : 32'd0);
    check({tag, ".overflow"},    32'(bus.overflow),    32'(m_ovf));
    check({tag, ".exhausted"},   32'(bus.exhausted),   32'(m_exh));
    check({tag, ".hitCount"},    32'(bus.hitCount),    32'(m_hits));
    check({tag, ".blockActive"}, 32'(bus.blockActive), 32'(in_block));
  endtask

  // Drive one cycle of inputs on the falling edge, check just after the rising edge.
  task automatic step(input string tag, input bit rv, input bit succ, input bit nb, input bit rdy);
    @(negedge clk);
    bus.resultValid = rv;
    bus.success     = rv ? succ : 1'($urandom);
    bus.newBlockIn  = rv ? nb   : 1'($urandom);
    bus.nonceReady  = rdy;
    model_edge(rv, succ, nb, rdy);
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  initial begin
    rst             = 1'b0;
    bus.resultValid = 1'b0;
    bus.success     = 1'b0;
    bus.newBlockIn  = 1'b0;
    bus.nonceReady  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    @(negedge clk);
    rst = 1'b1;

    // Results before any block opens are ignored.
    for (int i = 0; i < 3; i++) step("pre_block", 1'b1, 1'b1, 1'b0, 1'b1);
    check("pre_block.hit_const", 32'(bus.hitCount), 32'd0);

    // Block with winners at index 0 and 3, consumer always ready.
    step("basic0", 1'b1, 1'b1, 1'b1, 1'b1);
    check("basic0.head_const", 32'(bus.nonceOut), 32'd0);
    step("basic1", 1'b1, 1'b0, 1'b0, 1'b1);
    step("basic2", 1'b1, 1'b0, 1'b0, 1'b1);
    step("basic3", 1'b1, 1'b1, 1'b0, 1'b1);
    check("basic3.head_const", 32'(bus.nonceOut), 32'd3);
    step("basic4", 1'b1, 1'b0, 1'b0, 1'b1);
    check("basic4.hit_const", 32'(bus.hitCount), 32'd2);

    // Consumer stalled: six winners fill the FIFO and overflow it.
    step("ovf_nb", 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step("ovf_fill", 1'b1, 1'b1, 1'b0, 1'b0);
    check("ovf.flag_const", 32'(bus.overflow), 32'd1);
    check("ovf.hit_const", 32'(bus.hitCount), 32'd6);
    step("ovf_clear", 1'b1, 1'b0, 1'b1, 1'b0);
    check("ovf_clear.flag_const", 32'(bus.overflow), 32'd0);
    check("ovf_clear.head_const", 32'(bus.nonceOut), 32'd0);

    // Full FIFO with simultaneous push and pop, then drain and check order.
    step("full_pp", 1'b1, 1'b1, 1'b0, 1'b1);
    check("full_pp.flag_const", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 5; i++) step("drain", 1'b0, 1'b0, 1'b0, 1'b1);

    // Single entry held, then push and pop together.
    step("one_push", 1'b1, 1'b1, 1'b0, 1'b0);
    step("one_pp", 1'b1, 1'b1, 1'b0, 1'b1);
    step("one_drain", 1'b0, 1'b0, 1'b0, 1'b1);

    // Counter wrap: index 15 processed, next result ignored.
    step("wrap_nb", 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i < IDX_MOD - 1; i++) step("wrap_run", 1'b1, 1'b0, 1'b0, 1'b1);
    step("wrap_last", 1'b1, 1'b1, 1'b0, 1'b1);
    check("wrap.exh_const", 32'(bus.exhausted), 32'd1);
    check("wrap.hit_const", 32'(bus.hitCount), 32'd1);
    step("wrap_ignored", 1'b1, 1'b1, 1'b0, 1'b1);
    check("wrap_ignored.hit_const", 32'(bus.hitCount), 32'd1);
    step("wrap_restart", 1'b1, 1'b1, 1'b1, 1'b1);

    // Hit counter saturation.
    step("sat_nb", 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) step("sat_run", 1'b1, 1'b1, 1'b0, 1'b1);
    check("sat.hit_const", 32'(bus.hitCount), 32'(HIT_SAT));

    // Asynchronous reset mid-block with two entries queued.
    step("rst_nb", 1'b1, 1'b1, 1'b1, 1'b0);
    step("rst_q2", 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    compare_all("async_rst");
    @(negedge clk);
    rst = 1'b1;
    step("post_rst", 1'b1, 1'b1, 1'b0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom % 4) != 0, 1'($urandom), ($urandom % 20) == 0, ($urandom % 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
